// File: rtl/ssd_scan_driver.sv
// ---------------------------------------------------------------------------
// ssd_scan_driver
//   Time-multiplexes a 20-bit symbol word (four 5-bit codes) onto a 4-digit
//   common-anode seven-segment display. A prescaler sets the digit slot
//   length, a 2-bit scan counter walks the digits, and a shadow register
//   captures the input word once per frame so a frame never mixes two words.
//   A frame counter drives a shared blink phase that individual digits can
//   opt into.
//
// Ports
//   clk    in   system clock
//   rst    in   asynchronous active-high reset
//   en     in   display enable (0 = all anodes off; scanning continues)
//   ssd    in   [19:15]=digit3 ... [4:0]=digit0 symbol codes
//   blink  in   per-digit blink request, bit i = digit i (sampled live)
//   an     out  anode selects, active-low, registered
//   seg    out  cathodes {g,f,e,d,c,b,a}, active-low, registered
//   dp     out  decimal point, active-low, tied off (1)
//   frame  out  one-cycle pulse in the cycle after the shadow register loads
// ---------------------------------------------------------------------------
module ssd_scan_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [19:0] ssd,
  input  logic [3:0]  blink,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [19:0] BLANK_WORD = {4{5'b10000}};

  logic [PW-1:0] r_presc;
  logic [1:0]    r_digit;
  logic [19:0]   r_shadow;
  logic [FW-1:0] r_frame_cnt;
  logic          r_blink_phase;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_frame;

  logic          w_tick;
  logic [4:0]    w_sym_arr [4];
  logic [4:0]    w_sym;
  logic [6:0]    w_seg_dec;

  assign w_tick = (r_presc == PW'(REFRESH_DIV - 1));

  // Split the shadow word into per-digit symbol lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_sym_arr[gi] = r_shadow[gi*5 +: 5];
    end
  endgenerate

  assign w_sym = w_sym_arr[r_digit];

  // Symbol code to active-low segment pattern {g,f,e,d,c,b,a}.
  always_comb begin
    w_seg_dec = 7'h7F;
    case (w_sym)
      5'd0:  w_seg_dec = 7'h40;
      5'd1:  w_seg_dec = 7'h79;
      5'd2:  w_seg_dec = 7'h24;
      5'd3:  w_seg_dec = 7'h30;
      5'd4:  w_seg_dec = 7'h19;
      5'd5:  w_seg_dec = 7'h12;
      5'd6:  w_seg_dec = 7'h02;
      5'd7:  w_seg_dec = 7'h78;
      5'd8:  w_seg_dec = 7'h00;
      5'd9:  w_seg_dec = 7'h10;
      5'd10: w_seg_dec = 7'h08;  // A
      5'd11: w_seg_dec = 7'h03;  // b
      5'd12: w_seg_dec = 7'h46;  // C
      5'd13: w_seg_dec = 7'h21;  // d
      5'd14: w_seg_dec = 7'h06;  // E
      5'd15: w_seg_dec = 7'h0E;  // F
      5'd16: w_seg_dec = 7'h7F;  // blank
      5'd17: w_seg_dec = 7'h47;  // L
      5'd19: w_seg_dec = 7'h0C;  // P
      5'd20: w_seg_dec = 7'h2B;  // n
      default: w_seg_dec = 7'h7F;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc       <= '0;
      r_digit       <= 2'd0;
      r_shadow      <= BLANK_WORD;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
      r_an          <= 4'hF;
      r_seg         <= 7'h7F;
      r_frame       <= 1'b0;
    end else begin
      r_frame <= 1'b0;

      if (w_tick) begin
        r_presc <= '0;
        r_digit <= r_digit + 2'd1;
        // Wrap 3->0 is the frame boundary: the only point where the input
        // word is captured, so a frame is always drawn from a single word.
        if (r_digit == 2'd3) begin
          r_shadow <= ssd;
          r_frame  <= 1'b1;
          if (r_frame_cnt == FW'(BLINK_FRAMES - 1)) begin
            r_frame_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
          end else begin
            r_frame_cnt <= r_frame_cnt + FW'(1);
          end
        end
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // Outputs follow the current scan position one clock later. A blinked
      // digit keeps its anode driven and only blanks the cathodes.
      r_an  <= en ? ~(4'b0001 << r_digit) : 4'hF;
      r_seg <= (blink[r_digit] && r_blink_phase) ? 7'h7F : w_seg_dec;
    end
  end

  assign an    = r_an;
  assign seg   = r_seg;
  assign dp    = 1'b1;
  assign frame = r_frame;

endmodule

// File: tb/tb_ssd_scan_driver.sv
module tb_ssd_scan_driver;

  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME_LEN = 4 * RD;

  logic        clk;
  logic        rst;
  logic        en;
  logic [19:0] ssd;
  logic [3:0]  blink;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame;

  int tests_run;
  int tests_failed;

  // Reference model state: k = clock edges since reset release,
  // m_wraps = completed frames, m_shadow = word shown in the current frame.
  int          k;
  int          m_wraps;
  logic [19:0] m_shadow;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_frame;

  ssd_scan_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .ssd   (ssd),
    .blink (blink),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] dec(input logic [4:0] c);
    case (c)
      5'd0:  return 7'h40;
      5'd1:  return 7'h79;
      5'd2:  return 7'h24;
      5'd3:  return 7'h30;
      5'd4:  return 7'h19;
      5'd5:  return 7'h12;
      5'd6:  return 7'h02;
      5'd7:  return 7'h78;
      5'd8:  return 7'h00;
      5'd9:  return 7'h10;
      5'd10: return 7'h08;
      5'd11: return 7'h03;
      5'd12: return 7'h46;
      5'd13: return 7'h21;
      5'd14: return 7'h06;
      5'd15: return 7'h0E;
      5'd17: return 7'h47;
      5'd19: return 7'h0C;
      5'd20: return 7'h2B;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [19:0] pack(input logic [4:0] d3, input logic [4:0] d2,
                                       input logic [4:0] d1, input logic [4:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  // Advance one clock and compute what the display must show afterwards.
  // Scan position and blink phase come straight from the edge count.
  task automatic step();
    int          d;
    int          phase;
    logic [19:0] ssd_s;
    logic [4:0]  sym;
    d       = (k / RD) % 4;
    phase   = (m_wraps / BF) % 2;
    sym     = m_shadow[d*5 +: 5];
    ssd_s   = ssd;
    exp_an  = en ? ~(4'b0001 << d) : 4'hF;
    exp_seg = (blink[d] && phase == 1) ? 7'h7F : dec(sym);
    @(posedge clk);
    k++;
    if (k % FRAME_LEN == 0) begin
      m_shadow  = ssd_s;
      m_wraps++;
      exp_frame = 1'b1;
    end else begin
      exp_frame = 1'b0;
    end
    #1;
  endtask

  task automatic model_reset();
    k        = 0;
    m_wraps  = 0;
    m_shadow = {4{5'b10000}};
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    tests_run += 4;
    if (an !== 4'hF) begin tests_failed++; $display("FAIL reset_an got %b exp 1111", an); end
    if (seg !== 7'h7F) begin tests_failed++; $display("FAIL reset_seg got %h exp 7f", seg); end
    if (frame !== 1'b0) begin tests_failed++; $display("FAIL reset_frame got %b exp 0", frame); end
    if (dp !== 1'b1) begin tests_failed++; $display("FAIL reset_dp got %b exp 1", dp); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    $display("[TB] reset checked");
  endtask

  task automatic test_first_frames();
    en    = 1'b1;
    blink = 4'b0000;
    ssd   = pack(5'b01100, 5'b10001, 5'b00101, 5'b01101);
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      step();
      tests_run += 3;
      if (an !== exp_an) begin tests_failed++; $display("FAIL first_an k=%0d got %b exp %b", k, an, exp_an); end
      if (seg !== exp_seg) begin tests_failed++; $display("FAIL first_seg k=%0d got %h exp %h", k, seg, exp_seg); end
      if (frame !== exp_frame) begin tests_failed++; $display("FAIL first_frame k=%0d got %b exp %b", k, frame, exp_frame); end
    end
    // Spot values from the display itself: digit 0 of the second frame is 'd'.
    tests_run++;
    if (k != 32 || m_wraps != 2) begin tests_failed++; $display("FAIL first_count k=%0d exp 32", k); end
    $display("[TB] first_frames done k=%0d", k);
  endtask

  task automatic test_midframe_change();
    for (int i = 0; i < RD + 2; i++) begin
      step();
      tests_run += 2;
      if (an !== exp_an) begin tests_failed++; $display("FAIL mid_an k=%0d got %b exp %b", k, an, exp_an); end
      if (seg !== exp_seg) begin tests_failed++; $display("FAIL mid_seg k=%0d got %h exp %h", k, seg, exp_seg); end
    end
    ssd = pack(5'b00000, 5'b10011, 5'b01110, 5'b10100);
    for (int i = 0; i < 2 * FRAME_LEN - RD - 2; i++) begin
      step();
      tests_run += 3;
      if (an !== exp_an) begin tests_failed++; $display("FAIL mid_an k=%0d got %b exp %b", k, an, exp_an); end
      if (seg !== exp_seg) begin tests_failed++; $display("FAIL mid_seg k=%0d got %h exp %h", k, seg, exp_seg); end
      if (frame !== exp_frame) begin tests_failed++; $display("FAIL mid_frame k=%0d got %b exp %b", k, frame, exp_frame); end
    end
    $display("[TB] midframe_change done k=%0d", k);
  endtask

  task automatic test_blink();
    blink = 4'b0001;
    for (int i = 0; i < 5 * FRAME_LEN; i++) begin
      step();
      tests_run += 3;
      if (an !== exp_an) begin tests_failed++; $display("FAIL blink_an k=%0d got %b exp %b", k, an, exp_an); end
      if (seg !== exp_seg) begin tests_failed++; $display("FAIL blink_seg k=%0d got %h exp %h", k, seg, exp_seg); end
      if (frame !== exp_frame) begin tests_failed++; $display("FAIL blink_frame k=%0d got %b exp %b", k, frame, exp_frame); end
    end
    blink = 4'b0000;
    $display("[TB] blink done k=%0d", k);
  endtask

  task automatic test_decode_odd();
    ssd = pack(5'b10010, 5'b11111, 5'b10000, 5'b01111);
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      step();
      tests_run += 2;
      if (an !== exp_an) begin tests_failed++; $display("FAIL odd_an k=%0d got %b exp %b", k, an, exp_an); end
      if (seg !== exp_seg) begin tests_failed++; $display("FAIL odd_seg k=%0d got %h exp %h", k, seg, exp_seg); end
    end
    $display("[TB] decode_odd done k=%0d", k);
  endtask

  task automatic test_enable();
    en = 1'b0;
    for (int i = 0; i < 3 * FRAME_LEN; i++) begin
      step();
      tests_run += 2;
      if (an !== 4'hF) begin tests_failed++; $display("FAIL en_an k=%0d got %b exp 1111", k, an); end
      if (frame !== exp_frame) begin tests_failed++; $display("FAIL en_frame k=%0d got %b exp %b", k, frame, exp_frame); end
    end
    en = 1'b1;
    for (int i = 0; i < FRAME_LEN; i++) begin
      step();
      tests_run += 2;
      if (an !== exp_an) begin tests_failed++; $display("FAIL en_an k=%0d got %b exp %b", k, an, exp_an); end
      if (seg !== exp_seg) begin tests_failed++; $display("FAIL en_seg k=%0d got %h exp %h", k, seg, exp_seg); end
    end
    $display("[TB] enable done k=%0d", k);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        ssd = pack(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 15) == 0) blink = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) en = ~en;
      step();
      tests_run += 3;
      if (an !== exp_an) begin tests_failed++; $display("FAIL rand_an k=%0d got %b exp %b", k, an, exp_an); end
      if (seg !== exp_seg) begin tests_failed++; $display("FAIL rand_seg k=%0d got %h exp %h", k, seg, exp_seg); end
      if (frame !== exp_frame) begin tests_failed++; $display("FAIL rand_frame k=%0d got %b exp %b", k, frame, exp_frame); end
    end
    $display("[TB] random done k=%0d", k);
  endtask

  task automatic test_reset_midframe();
    en    = 1'b1;
    blink = 4'b0000;
    ssd   = pack(5'd1, 5'd2, 5'd3, 5'd4);
    for (int i = 0; i < FRAME_LEN + 6; i++) step();
    rst = 1'b1;
    #1;
    tests_run += 3;
    if (an !== 4'hF) begin tests_failed++; $display("FAIL rstmid_an got %b exp 1111", an); end
    if (seg !== 7'h7F) begin tests_failed++; $display("FAIL rstmid_seg got %h exp 7f", seg); end
    if (frame !== 1'b0) begin tests_failed++; $display("FAIL rstmid_frame got %b exp 0", frame); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2 * FRAME_LEN; i++) begin
      step();
      tests_run += 3;
      if (an !== exp_an) begin tests_failed++; $display("FAIL rstmid_an k=%0d got %b exp %b", k, an, exp_an); end
      if (seg !== exp_seg) begin tests_failed++; $display("FAIL rstmid_seg k=%0d got %h exp %h", k, seg, exp_seg); end
      if (frame !== exp_frame) begin tests_failed++; $display("FAIL rstmid_frame k=%0d got %b exp %b", k, frame, exp_frame); end
    end
    $display("[TB] reset_midframe done k=%0d", k);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b0;
    en    = 1'b1;
    ssd   = '0;
    blink = 4'b0000;
    model_reset();
    exp_an    = 4'hF;
    exp_seg   = 7'h7F;
    exp_frame = 1'b0;
    #2;
    test_reset();
    test_first_frames();
    test_midframe_change();
    test_blink();
    test_decode_odd();
    test_enable();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ssd_scan_driver.md
Name: ssd_scan_driver

Overview:
- Consumes the 20-bit symbol word produced by the lock controller: four 5-bit symbol codes, digit 3 leftmost.
- Time-multiplexes the word onto a 4-digit common-anode seven-segment display.
- Contains a refresh prescaler, digit scan counter, frame-synchronous shadow register (no tearing), symbol-to-segment decoder and per-digit blink.
- Sits between the lock controller and the board display pins.

Parameters:
- REFRESH_DIV, 50000: clk cycles per digit slot; minimum 2.
- BLINK_FRAMES, 64: full scan frames per blink half-period; minimum 1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- en  input  1  display enable; 0 forces all anodes off
- ssd  input  20  symbol word; [19:15] digit3 (an[3]), ..., [4:0] digit0 (an[0])
- blink  input  4  per-digit blink request, bit i = digit i
- an  output  4  anode selects, active-low, registered
- seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered
- dp  output  1  decimal point, active-low; constant 1
- frame  output  1  one-cycle pulse when the shadow register loads

Behaviour:
- Reset (async) values:
  - an=4'b1111, seg=7'h7F, dp=1, frame=0
  - prescaler=0, digit=0, shadow = four blank codes (5'b10000 each), frame_cnt=0, blink_phase=0
- Prescaler counts 0..REFRESH_DIV-1 and wraps. tick is asserted in the cycle where prescaler==REFRESH_DIV-1.
- On tick:
  - digit advances 0→1→2→3→0.
  - On the 3→0 wrap, the same edge:
    - loads shadow<=ssd and pulses frame=1 for one cycle
    - increments frame_cnt
    - when frame_cnt reaches BLINK_FRAMES-1, clears frame_cnt and toggles blink_phase
- ssd is sampled only at the 3→0 wrap; changes mid-frame are ignored until the next wrap.
- Outputs are registered each cycle from the current digit/shadow/blink_phase, so an/seg lag digit by one clk.
  - an = one-hot-low of digit when en=1; 4'b1111 when en=0.
  - seg = decode(shadow symbol for digit), except 7'h7F when blink[digit]=1 and blink_phase=1. The anode stays driven during a blinked digit.
- blink is sampled live, not shadowed.
- en does not stop the prescaler, scan, shadow loads or frame pulses.
- Decode table (active-low seg):
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10
  - Hex letters: A=08, b=03, C=46, d=21, E=06, F=0E
  - Other symbols: blank 10000=7F, L 10001=47, P 10011=0C, n 10100=2B
  - All other codes (10010, 10101..11111) = 7F (blank).
- Mid-operation reset clears all state immediately. The first shadow load after release happens at the first 3→0 wrap, 4·REFRESH_DIV cycles later. Until then the display shows blanks on a scanning anode.
- After reset release with en=1, the first clk edge gives an=4'b1110, seg=7F.

Test Plan:
- Use REFRESH_DIV=4, BLINK_FRAMES=2 throughout.
- Reset, then hold en=1, ssd={C,L,5,d}={01100,10001,00101,01101}, blink=0:
  - first frame shows blanks, with an sequence 1110,1101,1011,0111 each held 4 cycles.
  - frame pulses at cycle 16.
  - second frame shows seg 21 (an0), 12 (an1), 47 (an2), 46 (an3).
- Change ssd to {0,P,E,n} during digit 1 of a frame:
  - the remaining digits of that frame still show the old word.
  - the new word shows only after the next frame pulse: seg 2B, 06, 0C, 40.
- blink=4'b0001 with ssd={0,P,E,n}:
  - an0 slot shows 2B for 2 frames, then 7F for 2 frames, repeating.
  - other digits are unaffected.
  - an stays 1110 in that slot.
- ssd={10010,11111,10000,01111}: decoded digits give 0E (digit 0), 7F, 7F, 7F.
- en=0 for 3 frames → an=1111 throughout while frame pulses continue every 16 cycles. Return en=1 → the correct digit appears on the next clk.
- Assert rst mid-frame for 1 cycle:
  - an=1111 and seg=7F immediately (async).
  - after release, the scan restarts at digit 0 and shadow is blank until the next frame pulse at +16 cycles.
